ddr_axi_slave: RTL and testbench

Synthesizable AXI4 slave memory: the responder that terminates the AXI4 master port of the external-memory L2 cache (`iob_cache_axi`). It serves the cache's write and read bursts from an internal byte-writable RAM. It is used in simulation and FPGA builds without a memory controller (MIG). It handles one transaction at a time, with full-throughput data beats and AXI-compliant back-pressure on every channel.

---
 rtl/ddr_axi_slave.sv | 174 +++++++++++++++++
 tb/tb_ddr_axi_slave.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_axi_slave.sv
// AXI4 slave backed by a byte-writable synchronous RAM; stands in for the external
// DDR controller behind the L2 cache and serves one burst at a time.
//
// state   | meaning
// IDLE    | waiting for an AW or AR handshake (write wins a tie)
// WR_DATA | accepting W beats until the latched length is reached
// WR_RESP | presenting the B response until bready
// RD_DATA | streaming R beats out of the RAM, one read in flight at most
module ddr_axi_slave #(
  parameter int DDR_ADDR_W = 30,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  axi_awid,
  input  logic [DDR_ADDR_W-1:0] axi_awaddr,
  input  logic [7:0]            axi_awlen,
  input  logic [1:0]            axi_awburst,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,

  input  logic [DATA_W-1:0]     axi_wdata,
  input  logic [DATA_W/8-1:0]   axi_wstrb,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,

  output logic                  axi_bid,
  output logic [1:0]            axi_bresp,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,

  input  logic                  axi_arid,
  input  logic [DDR_ADDR_W-1:0] axi_araddr,
  input  logic [7:0]            axi_arlen,
  input  logic [1:0]            axi_arburst,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,

  output logic                  axi_rid,
  output logic [DATA_W-1:0]     axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rlast,
  output logic                  axi_rvalid,
  input  logic                  axi_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int B      = $clog2(STRB_W);
  localparam int DEPTH  = 2 ** MEM_ADDR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [MEM_ADDR_W-1:0] idx;
  logic [7:0]            len;
  logic                  fixed;
  logic                  id;
  logic [8:0]            cnt;
  logic                  rvalid;
  logic                  rlast;
  logic [DATA_W-1:0]     rdata;

  logic [DATA_W-1:0] mem [DEPTH];

  logic aw_hs, ar_hs, w_hs, b_hs, r_hs, rd_issue, at_len;

  // Only the word-index bits of the byte address select RAM; the rest wraps.
  wire unused_addr = ^{axi_awaddr, axi_araddr};

  assign axi_awready = (state == IDLE);
  assign axi_arready = (state == IDLE) && !axi_awvalid;
  assign axi_wready  = (state == WR_DATA);
  assign axi_bvalid  = (state == WR_RESP);
  assign axi_bid     = id;
  assign axi_bresp   = 2'b00;
  assign axi_rid     = id;
  assign axi_rresp   = 2'b00;
  assign axi_rvalid  = rvalid;
  assign axi_rlast   = rlast;
  assign axi_rdata   = rdata;

  assign aw_hs  = axi_awvalid && axi_awready;
  assign ar_hs  = axi_arvalid && axi_arready;
  assign w_hs   = axi_wvalid && axi_wready;
  assign b_hs   = axi_bvalid && axi_bready;
  assign r_hs   = rvalid && axi_rready;
  assign at_len = (cnt == {1'b0, len});

  // A new read may enter the 1-deep output stage when it is empty or draining.
  assign rd_issue = (state == RD_DATA) && (!rvalid || axi_rready) && (cnt <= {1'b0, len});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (aw_hs)      state_nxt = WR_DATA;
        else if (ar_hs) state_nxt = RD_DATA;
      end
      WR_DATA: begin
        if (w_hs && at_len) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) state_nxt = IDLE;
      end
      RD_DATA: begin
        if (r_hs && rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      len   <= '0;
      fixed <= 1'b0;
      id    <= 1'b0;
      cnt   <= '0;
    end else if (aw_hs) begin
      idx   <= axi_awaddr[MEM_ADDR_W+B-1:B];
      len   <= axi_awlen;
      fixed <= (axi_awburst == 2'b00);
      id    <= axi_awid;
      cnt   <= '0;
    end else if (ar_hs) begin
      idx   <= axi_araddr[MEM_ADDR_W+B-1:B];
      len   <= axi_arlen;
      fixed <= (axi_arburst == 2'b00);
      id    <= axi_arid;
      cnt   <= '0;
    end else if (w_hs || rd_issue) begin
      cnt <= cnt + 9'd1;
      if (!fixed) idx <= idx + MEM_ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      rdata  <= '0;
    end else if (rd_issue) begin
      rvalid <= 1'b1;
      rlast  <= at_len;
      rdata  <= mem[idx];
    end else if (r_hs) begin
      rvalid <= 1'b0;
      rlast  <= 1'b0;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (axi_wstrb[i]) mem[idx][i*8 +: 8] <= axi_wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ddr_axi_slave.sv
// Scoreboard bench for ddr_axi_slave: a word-array memory model predicts read data,
// and a negedge monitor checks every R and B handshake against queued expectations.
module tb_ddr_axi_slave;
  localparam int DW = 32, AW = 30, MAW = 14, DEPTH = 1 << MAW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic axi_awid = 0, axi_awvalid = 0, axi_awready;
  logic [AW-1:0] axi_awaddr = '0;
  logic [7:0] axi_awlen = '0;
  logic [1:0] axi_awburst = 2'b01;
  logic [DW-1:0] axi_wdata = '0;
  logic [DW/8-1:0] axi_wstrb = '0;
  logic axi_wvalid = 0, axi_wready;
  logic axi_bid, axi_bvalid, axi_bready = 1;
  logic [1:0] axi_bresp;
  logic axi_arid = 0, axi_arvalid = 0, axi_arready;
  logic [AW-1:0] axi_araddr = '0;
  logic [7:0] axi_arlen = '0;
  logic [1:0] axi_arburst = 2'b01;
  logic axi_rid, axi_rlast, axi_rvalid, axi_rready = 1;
  logic [DW-1:0] axi_rdata;
  logic [1:0] axi_rresp;

  ddr_axi_slave #(.DDR_ADDR_W(AW), .DATA_W(DW), .MEM_ADDR_W(MAW)) dut (
    .clk(clk), .rst(rst),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  logic [31:0] model [DEPTH];

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        id;
    int          t;
  } rexp_t;

  rexp_t rq[$];
  logic  bq_id[$];
  int    bq_t[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  int rd_done = 0, rd_beats = 0, wr_done = 0;
  logic [31:0] last_rdata = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic die(string name);
    n_tests++;
    n_fail++;
    $display("FAIL timeout_%s actual=no_handshake required=handshake", name);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "bench stopped");
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_awready"}, axi_awready, 1);
    chk({tag, "_arready"}, axi_arready, 1);
    chk({tag, "_wready"},  axi_wready, 0);
    chk({tag, "_bvalid"},  axi_bvalid, 0);
    chk({tag, "_rvalid"},  axi_rvalid, 0);
    chk({tag, "_rlast"},   axi_rlast, 0);
    chk({tag, "_rdata"},   axi_rdata, 0);
    chk({tag, "_ids"},     {axi_bid, axi_rid}, 0);
    chk({tag, "_resp"},    {axi_bresp, axi_rresp}, 0);
  endtask

  // Monitor: every handshake the DUT completes is matched to the head of a queue.
  rexp_t e;
  logic prev_stall = 0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("r_stall_valid", axi_rvalid, 1);
        chk("r_stall_data", axi_rdata, prev_data);
      end
      prev_stall = axi_rvalid && !axi_rready;
      prev_data  = axi_rdata;
      if (axi_rvalid && axi_rready) begin
        if (rq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL r_unexpected actual=beat required=none data=%0h", axi_rdata);
        end else begin
          e = rq.pop_front();
          chk("r_data", axi_rdata, e.data);
          chk("r_last", axi_rlast, e.last);
          chk("r_id", axi_rid, e.id);
          chk("r_resp", axi_rresp, 0);
          if (e.t >= 0) chk("r_cycle", cyc, e.t);
          last_rdata = axi_rdata;
          rd_beats++;
          if (axi_rlast) rd_done++;
        end
      end
      if (axi_bvalid && axi_bready) begin
        if (bq_id.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected actual=bvalid required=none");
        end else begin
          chk("b_id", axi_bid, bq_id.pop_front());
          chk("b_resp", axi_bresp, 0);
          if (bq_t[0] >= 0) chk("b_cycle", cyc, bq_t[0]);
          void'(bq_t.pop_front());
          wr_done++;
        end
      end
    end
  end

  function automatic int word_of(int addr);
    return (addr / 4) % DEPTH;
  endfunction

  task automatic do_write(int addr, int len, logic [1:0] burst, logic id, bit gaps, bit bstall, bit rnd_strb);
    int t_aw, idx, to, n, d0;
    logic [31:0] d;
    logic [3:0] s;
    axi_awaddr = addr[AW-1:0]; axi_awlen = len[7:0]; axi_awburst = burst; axi_awid = id;
    axi_awvalid = 1;
    to = 0;
    @(negedge clk);
    while (!axi_awready) begin
      if (++to > 500) die("aw");
      @(negedge clk);
    end
    t_aw = cyc;
    @(posedge clk); #1;
    axi_awvalid = 0;
    bq_id.push_back(id);
    bq_t.push_back((gaps || bstall) ? -1 : t_aw + 2 + len);
    idx = word_of(addr);
    d0 = wr_done;
    for (int b = 0; b <= len; b++) begin
      if (gaps) begin
        n = $urandom_range(0, 2);
        if (n > 0) begin
          axi_wvalid = 0;
          repeat (n) @(posedge clk);
          #1;
        end
      end
      if (wd_q.size() > 0) begin
        d = wd_q.pop_front();
        s = ws_q.pop_front();
      end else begin
        d = $urandom;
        s = rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF;
      end
      axi_wdata = d; axi_wstrb = s; axi_wvalid = 1;
      to = 0;
      @(negedge clk);
      while (!axi_wready) begin
        if (++to > 500) die("w");
        @(negedge clk);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
    axi_wvalid = 0;
    if (bstall) begin
      axi_bready = 0;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    axi_bready = 1;
    to = 0;
    while (wr_done == d0) begin
      @(posedge clk); #1;
      if (++to > 500) die("b");
    end
  endtask

  // mode: 0 rready high, 1 pattern 1,0,0 repeating, 2 random
  task automatic do_read(int addr, int len, logic [1:0] burst, logic id, int mode, int abort_after);
    int t_ar, idx, to, d0, b0, k;
    axi_araddr = addr[AW-1:0]; axi_arlen = len[7:0]; axi_arburst = burst; axi_arid = id;
    axi_arvalid = 1;
    axi_rready = 1;
    to = 0;
    @(negedge clk);
    while (!axi_arready) begin
      if (++to > 500) die("ar");
      @(negedge clk);
    end
    t_ar = cyc;
    d0 = rd_done;
    b0 = rd_beats;
    @(posedge clk); #1;
    axi_arvalid = 0;
    idx = word_of(addr);
    for (int b = 0; b <= len; b++) begin
      rq.push_back('{model[idx], b == len, id, (mode == 0) ? t_ar + 2 + b : -1});
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
    k = 0;
    to = 0;
    while (rd_done == d0) begin
      if (abort_after >= 0 && rd_beats - b0 > abort_after) break;
      axi_rready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      k++;
      @(posedge clk); #1;
      if (++to > 2000) die("r");
    end
    axi_rready = 1;
  endtask

  int a, l, abort_word;
  logic [1:0] bu;

  initial begin
    #1;
    chk_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Prefill the region used by random traffic plus the top-of-RAM wrap window.
    for (int r = 0; r < 4; r++) do_write(r * 1024, 255, 2'b01, 0, 0, 0, 0);
    do_write((DEPTH - 4) * 4, 7, 2'b01, 1, 0, 0, 0);
    do_read((DEPTH - 4) * 4, 7, 2'b01, 1, 0, -1);

    wd_q.push_back(32'hDEADBEEF); ws_q.push_back(4'hF);
    do_write(32'h100, 0, 2'b01, 0, 0, 0, 0);
    do_read(32'h100, 0, 2'b01, 0, 0, -1);
    chk("single_rdata", last_rdata, 32'hDEADBEEF);

    for (int i = 0; i < 16; i++) begin wd_q.push_back(i); ws_q.push_back(4'hF); end
    do_write(32'h200, 15, 2'b01, 1, 0, 0, 0);
    do_read(32'h200, 15, 2'b01, 1, 0, -1);

    wd_q.push_back(32'hFFFFFFFF); ws_q.push_back(4'hF);
    wd_q.push_back(32'h12345678); ws_q.push_back(4'b0101);
    do_write(32'h300, 1, 2'b00, 0, 0, 0, 0);
    do_read(32'h300, 0, 2'b01, 0, 0, -1);
    chk("strobe_merge", last_rdata, 32'hFF34FF78);

    do_write(32'h400, 7, 2'b01, 1, 1, 1, 0);
    do_read(32'h400, 7, 2'b01, 1, 1, -1);

    wd_q.push_back(32'hA5); ws_q.push_back(4'hF);
    fork
      do_write(32'h500, 0, 2'b01, 1, 0, 0, 0);
      do_read(32'h500, 0, 2'b01, 0, 0, -1);
    join
    chk("aw_wins_rdata", last_rdata, 32'hA5);

    for (int i = 0; i < 4; i++) begin wd_q.push_back(32'h4444_0000 + i); ws_q.push_back(4'hF); end
    do_write(32'h40, 3, 2'b00, 0, 0, 0, 0);
    do_read(32'h40, 0, 2'b01, 0, 0, -1);
    chk("fixed_last_wins", last_rdata, 32'h4444_0003);
    do_read(32'h40, 3, 2'b00, 1, 2, -1);

    do_read(0, 255, 2'b01, 0, 2, -1);

    for (int k = 0; k < 30; k++) begin
      a  = ($urandom_range(0, 900) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 16383) << 16);
      l  = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 40) : $urandom_range(0, 15);
      bu = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, l, bu, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      else
        do_read(a, l, bu, 1'($urandom_range(0, 1)), $urandom_range(0, 2), -1);
    end

    // Reset in the middle of a 16-beat read, after beat 3 has been taken.
    do_read(32'h600, 15, 2'b01, 1, 0, 3);
    #1 rst = 1;
    #1 chk_reset_outputs("rst_mid");
    rq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    abort_word = 32'h600 + 4 * 9;
    do_read(abort_word, 0, 2'b01, 0, 0, -1);
    chk("post_reset_rdata", last_rdata, model[word_of(abort_word)]);

    repeat (5) @(posedge clk);
    #1;
    chk("rq_drained", rq.size(), 0);
    chk("bq_drained", bq_id.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
